// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed hex display blocks.
package seg_pkg;

   localparam int NIB_W      = 4;
   localparam int MAX_DIGITS = 8;

   // All digits dark; slice the low DIGITS bits for a given display width.
   localparam logic [MAX_DIGITS-1:0] DIGIT_OFF_N = '1;

   typedef enum logic [1:0] {
      ST_DARK,
      ST_GAP,
      ST_SHOW
   } scan_state_e;

   // Per-digit blank vector for leading-zero suppression. Digit i > 0 is
   // blanked when it and every more significant digit are zero; digit 0 is
   // never blanked so a zero value still shows a single "0".
   function automatic logic [MAX_DIGITS-1:0] lz_mask(
      input logic [MAX_DIGITS*NIB_W-1:0] value,
      input int                          digits
   );
      logic [MAX_DIGITS-1:0] mask;
      logic                  all_zero;
      mask     = '0;
      all_zero = 1'b1;
      for (int i = MAX_DIGITS - 1; i > 0; i--) begin
         if (i < digits) begin
            all_zero = all_zero & (value[i*NIB_W +: NIB_W] == '0);
            mask[i]  = all_zero;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Value/load inputs and scanned display outputs of seg_scan_mux.
interface seg_scan_mux_if
   import seg_pkg::*;
#(
   parameter int DIGITS = 4
);
   logic [NIB_W*DIGITS-1:0] value_in;
   logic                    load;
   logic [NIB_W-1:0]        nibble;
   logic [DIGITS-1:0]       digit_en_n;
   logic                    frame_done;

   modport master (
      output value_in, load,
      input  nibble, digit_en_n, frame_done
   );

   modport slave (
      input  value_in, load,
      output nibble, digit_en_n, frame_done
   );
endinterface

// File: rtl/seg_tick_gen.sv
// Digit-slot prescaler: free-running 0..PRESCALE-1 counter, tick on the last count.
module seg_tick_gen #(
   parameter int PRESCALE = 50000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);
   localparam int CNT_W = $clog2(PRESCALE);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CNT_W'(PRESCALE - 1));

   // Wrap to zero on the terminal count.
   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed hex display scanner with frame-aligned value swap and
// optional leading-zero suppression.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_DARK | after reset, all digits off until the first prescale tick
//   ST_GAP  | one-cycle ghosting guard after a tick; enables all off
//   ST_SHOW | current slot's enable/nibble driven until the next tick
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 50000,
   parameter int BLANK_LZ = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   seg_scan_mux_if.slave  bus
);
   localparam int                 IDX_W    = $clog2(DIGITS);
   localparam int                 VAL_W    = NIB_W * DIGITS;
   localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [DIGITS-1:0]  EN_OFF   = DIGIT_OFF_N[DIGITS-1:0];

   scan_state_e                 state_q, state_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [VAL_W-1:0]            disp_q, disp_d;
   logic [VAL_W-1:0]            pend_q, pend_d;
   logic                        pend_vld_q, pend_vld_d;
   logic [NIB_W-1:0]            nib_q, nib_d;
   logic [DIGITS-1:0]           en_q, en_d;
   logic                        fd_q, fd_d;
   logic                        tick;
   logic                        boundary;
   logic [MAX_DIGITS*NIB_W-1:0] disp_ext;
   logic [MAX_DIGITS-1:0]       blank;

   seg_tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // A tick leaving the last digit starts a new frame (idx wraps to 0).
   assign boundary = tick && (idx_q == IDX_LAST);

   // Blank vector from the value currently on display.
   always_comb begin
      disp_ext             = '0;
      disp_ext[VAL_W-1:0]  = disp_q;
      blank                = (BLANK_LZ != 0) ? lz_mask(disp_ext, DIGITS) : '0;
   end

   // Scan sequencing, frame-aligned shadow swap and load capture.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      en_d       = en_q;
      nib_d      = nib_q;
      fd_d       = 1'b0;
      disp_d     = disp_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;

      case (state_q)
         ST_GAP: begin
            state_d = ST_SHOW;
            nib_d   = disp_q[NIB_W*idx_q +: NIB_W];
            en_d    = EN_OFF;
            if (!blank[idx_q]) en_d[idx_q] = 1'b0;
         end
         ST_DARK, ST_SHOW: ;
         default: state_d = ST_DARK;
      endcase

      if (tick) begin
         state_d = ST_GAP;
         idx_d   = boundary ? '0 : idx_q + 1'b1;
         en_d    = EN_OFF;
         fd_d    = boundary;
      end

      if (boundary && pend_vld_q) begin
         disp_d     = pend_q;
         pend_vld_d = 1'b0;
      end

      // A load on the boundary bypasses the shadow and drops any older pending value.
      if (bus.load) begin
         if (boundary) begin
            disp_d     = bus.value_in;
            pend_vld_d = 1'b0;
         end else begin
            pend_d     = bus.value_in;
            pend_vld_d = 1'b1;
         end
      end
   end

   // State, shadow and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_DARK;
         idx_q      <= IDX_LAST;
         disp_q     <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         nib_q      <= '0;
         en_q       <= EN_OFF;
         fd_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         disp_q     <= disp_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         nib_q      <= nib_d;
         en_q       <= en_d;
         fd_q       <= fd_d;
      end
   end

   assign bus.nibble     = nib_q;
   assign bus.digit_en_n = en_q;
   assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: 4 digits, prescale 4; one instance with
// leading-zero blanking and one without (held at value 0).
module tb_seg_scan_mux;

   typedef struct {
      bit          l1;
      logic [15:0] v1;
      int          s1;
      int          o1;
      bit          l2;
      logic [15:0] v2;
      int          s2;
      int          o2;
      logic [15:0] exp_nib;
      logic [15:0] exp_en;
   } vec_t;

   typedef struct packed {
      logic [3:0] nib;
      logic [3:0] en;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   exp_t sb_q[$];
   vec_t vecs[7];
   logic [3:0] en_slot[4];

   seg_scan_mux_if #(.DIGITS(4)) bus1 ();
   seg_scan_mux_if #(.DIGITS(4)) bus2 ();

   seg_scan_mux #(.DIGITS(4), .PRESCALE(4), .BLANK_LZ(1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   seg_scan_mux #(.DIGITS(4), .PRESCALE(4), .BLANK_LZ(0)) u_dut_nolz (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [15:0] nib, input logic [15:0] en);
      exp_t e;
      for (int s = 0; s < 4; s++) begin
         e.nib = nib[4*s +: 4];
         e.en  = en[4*s +: 4];
         sb_q.push_back(e);
      end
   endtask

   // Cycles 0..3 after reset release: dark, no frame pulse.
   task automatic after_reset();
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("rst_en c%0d", c), 32'(bus1.digit_en_n), 32'hF);
         chk($sformatf("rst_fd c%0d", c), 32'(bus1.frame_done), 32'h0);
         chk($sformatf("rst_nib c%0d", c), 32'(bus1.nibble), 32'h0);
         chk($sformatf("rst_en_nolz c%0d", c), 32'(bus2.digit_en_n), 32'hF);
         @(negedge clk);
      end
   endtask

   // One frame of 4 slots x 4 cycles, entered at the slot-0 gap cycle.
   task automatic run_frame(input vec_t v, input int fr);
      exp_t cur;
      cur = '0;
      push_exp(v.exp_nib, v.exp_en);
      for (int s = 0; s < 4; s++) begin
         for (int o = 0; o < 4; o++) begin
            if (o == 0) begin
               chk($sformatf("gap_en f%0d s%0d", fr, s), 32'(bus1.digit_en_n), 32'hF);
               chk($sformatf("frame_done f%0d s%0d", fr, s), 32'(bus1.frame_done), 32'(s == 0));
               chk($sformatf("gap_en_nolz f%0d s%0d", fr, s), 32'(bus2.digit_en_n), 32'hF);
               if (s == 0)
                  chk($sformatf("pend_vld_at_frame f%0d", fr), 32'(u_dut.pend_vld_q), 32'h0);
            end else if (o == 1) begin
               if (sb_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL sb_empty f%0d s%0d: got no entry expected one", fr, s);
               end else begin
                  cur = sb_q.pop_front();
                  chk($sformatf("nib f%0d s%0d", fr, s), 32'(bus1.nibble), 32'(cur.nib));
                  chk($sformatf("en f%0d s%0d", fr, s), 32'(bus1.digit_en_n), 32'(cur.en));
               end
               chk($sformatf("en_nolz f%0d s%0d", fr, s), 32'(bus2.digit_en_n), 32'(en_slot[s]));
               chk($sformatf("nib_nolz f%0d s%0d", fr, s), 32'(bus2.nibble), 32'h0);
            end else begin
               chk($sformatf("fd_low f%0d s%0d o%0d", fr, s, o), 32'(bus1.frame_done), 32'h0);
               if (o == 3) begin
                  chk($sformatf("hold_nib f%0d s%0d", fr, s), 32'(bus1.nibble), 32'(cur.nib));
                  chk($sformatf("hold_en f%0d s%0d", fr, s), 32'(bus1.digit_en_n), 32'(cur.en));
               end
            end
            bus1.load = 1'b0;
            if (v.l1 && s == v.s1 && o == v.o1) begin
               bus1.load     = 1'b1;
               bus1.value_in = v.v1;
            end
            if (v.l2 && s == v.s2 && o == v.o2) begin
               bus1.load     = 1'b1;
               bus1.value_in = v.v2;
            end
            @(negedge clk);
         end
      end
      bus1.load = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      en_slot[0] = 4'b1110;
      en_slot[1] = 4'b1101;
      en_slot[2] = 4'b1011;
      en_slot[3] = 4'b0111;

      // {load1, val1, slot1, off1, load2, val2, slot2, off2, next-frame nibbles, next-frame enables}
      vecs[0] = '{1'b1, 16'h12A4, 1, 2, 1'b0, 16'h0000, 0, 0, 16'h12A4, 16'h7BDE};
      vecs[1] = '{1'b1, 16'h0005, 0, 1, 1'b1, 16'h0070, 2, 0, 16'h0070, 16'hFFDE};
      vecs[2] = '{1'b1, 16'h0009, 1, 0, 1'b1, 16'hBEEF, 3, 3, 16'hBEEF, 16'h7BDE};
      vecs[3] = '{1'b0, 16'h0000, 0, 0, 1'b0, 16'h0000, 0, 0, 16'hBEEF, 16'h7BDE};
      vecs[4] = '{1'b1, 16'h0300, 2, 1, 1'b0, 16'h0000, 0, 0, 16'h0300, 16'hFBDE};
      vecs[5] = '{1'b1, 16'h0008, 1, 0, 1'b0, 16'h0000, 0, 0, 16'h0008, 16'hFFFE};
      vecs[6] = '{1'b0, 16'h0000, 0, 0, 1'b0, 16'h0000, 0, 0, 16'h0000, 16'hFFFE};

      rst_n         = 1'b0;
      bus1.load     = 1'b0;
      bus1.value_in = '0;
      bus2.load     = 1'b0;
      bus2.value_in = '0;
      repeat (3) @(negedge clk);

      push_exp(16'h0000, 16'hFFFE);
      rst_n = 1'b1;
      after_reset();
      for (int f = 0; f < 6; f++) run_frame(vecs[f], f);

      // Frame 6 slot 0 gap: leave a pending load, then reset mid-slot.
      bus1.load     = 1'b1;
      bus1.value_in = 16'hFFFF;
      @(negedge clk);
      bus1.load = 1'b0;
      chk("pre_rst_nib", 32'(bus1.nibble), 32'h8);
      chk("pre_rst_en", 32'(bus1.digit_en_n), 32'hE);
      chk("pre_rst_pend_vld", 32'(u_dut.pend_vld_q), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_en", 32'(bus1.digit_en_n), 32'hF);
      chk("async_rst_nib", 32'(bus1.nibble), 32'h0);
      chk("async_rst_fd", 32'(bus1.frame_done), 32'h0);
      chk("async_rst_pend_vld", 32'(u_dut.pend_vld_q), 32'h0);
      chk("async_rst_en_nolz", 32'(bus2.digit_en_n), 32'hF);
      @(negedge clk);
      sb_q.delete();
      push_exp(16'h0000, 16'hFFFE);
      rst_n = 1'b1;
      after_reset();
      run_frame(vecs[6], 7);
      run_frame(vecs[6], 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
